// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int cXLEN = 32;
  localparam logic [cXLEN-1:0] cResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } tFetchState;

  typedef struct packed {
    logic [cXLEN-1:0] pc;
    logic [31:0]      inst;
  } tFetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding fetched words with their PCs.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tFetchEntry    push_data,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output tFetchEntry    head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tFetchEntry    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage carries data only; pointers decide what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// in-order response buffering and flush/redirect with stale-response dropping.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              XLEN     = cXLEN,
  parameter logic [XLEN-1:0] RESET_PC = cResetPc,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            flush_pipe,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] cDepthW = (CW + 1)'(DEPTH);

  tFetchState      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            keep;
  logic            pop;
  logic [XLEN-1:0] redirect_aligned;
  tFetchEntry      head;
  tFetchEntry      push_entry;

  // Buffered plus outstanding words never exceed DEPTH, so the FIFO cannot overflow.
  assign in_flight        = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid   = (state == FETCH) && !flush_pipe && (in_flight < cDepthW);
  assign imem_req_addr    = fetch_pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign keep             = imem_rsp_valid && !flush_pipe && (drop_cnt == '0);
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign push_entry       = '{pc: rsp_pc, inst: imem_rsp_data};

  assign inst_valid = !fifo_empty && (state != FLUSH) && !flush_pipe;
  assign pop        = inst_valid && inst_ready;
  assign inst       = fifo_empty ? '0 : head.inst;
  assign inst_pc    = fifo_empty ? '0 : head.pc;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (keep),
    .push_data(push_entry),
    .pop      (pop),
    .clear    (flush_pipe),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (flush_pipe) begin
      // Every request still in flight, minus the one answered now, returns stale.
      state       <= FLUSH;
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   state <= FETCH;
        FLUSH:   state <= FETCH;
        default: state <= IDLE;
      endcase
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (keep)   rsp_pc   <= rsp_pc + XLEN'(4);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: latency-programmable memory, request-level reference model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        flush_pipe = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  inst_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .flush_pipe    (flush_pipe),
    .redirect_pc   (redirect_pc)
  );

  int          tests  = 0;
  int          failed = 0;
  int unsigned cyc    = 0;
  int unsigned lat    = 1;

  typedef struct { logic [31:0] addr; int unsigned due; } memreq_t;
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  memreq_t     memq[$];
  pend_t       pend[$];
  ent_t        q[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];
  logic [31:0] m_fpc   = '0;
  bit          m_idle  = 1'b1;
  bit          m_bubble = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory: answers accepted requests in order, no earlier than lat cycles later.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Reference model: every outstanding request carries a stale flag set by flush.
  always @(negedge clk) begin : mon
    logic        e_req;
    logic        e_iv;
    int unsigned due;
    pend_t       p;
    e_req = !m_idle && !m_bubble && !flush_pipe && (q.size() + pend.size() < DEPTH);
    e_iv  = (q.size() > 0) && !m_bubble && !flush_pipe;
    if (m_valid) begin
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      if (e_req) check("req_addr", imem_req_addr, m_fpc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
      if (e_iv) begin
        check("inst", inst, q[0].word);
        check("inst_pc", inst_pc, q[0].pc);
      end
    end
    if (imem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
      memq.push_back('{imem_req_addr, due});
      acc_q.push_back(imem_req_addr);
    end
    if (inst_valid && inst_ready) pop_q.push_back(inst_pc);
    if (!rst) begin
      m_valid = 1'b1; m_idle = 1'b1; m_bubble = 1'b0; m_fpc = 32'h0;
      q.delete(); pend.delete(); memq.delete();
    end else if (m_valid) begin
      if (flush_pipe) begin
        if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
        foreach (pend[i]) pend[i].stale = 1'b1;
        q.delete();
        m_fpc    = {redirect_pc[31:2], 2'b00};
        m_bubble = 1'b1;
      end else begin
        if (e_iv && inst_ready) void'(q.pop_front());
        if (imem_rsp_valid && pend.size() > 0) begin
          p = pend.pop_front();
          if (!p.stale) begin
            if (q.size() >= DEPTH) begin
              failed++;
              $display("FAIL model_overflow: buffered %0d, limit %0d", q.size(), DEPTH);
            end
            q.push_back('{p.addr, mem_word(p.addr)});
          end
        end
        if (e_req && imem_req_ready) begin
          pend.push_back('{m_fpc, 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
        m_bubble = 1'b0;
      end
      m_idle = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.clear) begin
      failed++;
      $display("FAIL fifo_push_full: push=1 full=1, required no push while full");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush_pipe = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    acc_q.delete(); pop_q.delete();
  endtask

  task automatic wait_pops(input int n, input int limit);
    int k = 0;
    while (pop_q.size() < n && k < limit) begin tick(); k++; end
    if (pop_q.size() < n) begin
      tests++; failed++;
      $display("FAIL pop_timeout: got %0d instructions, expected %0d", pop_q.size(), n);
    end
  endtask

  function automatic logic [31:0] popped(input int i);
    return (i < pop_q.size()) ? pop_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] accepted(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    // Reset values, first-valid latency and sequential fetch.
    lat = 1; rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    tick();
    rst = 1'b1; acc_q.delete(); pop_q.delete();
    tick(); tick();
    @(negedge clk);
    check("first_valid_early", {31'b0, inst_valid}, 32'h0);
    tick();
    @(negedge clk);
    check("first_valid", {31'b0, inst_valid}, 32'h1);
    check("first_pc", inst_pc, 32'h0);
    check("first_word", inst, 32'h1357_9BDF);
    wait_pops(3, 20);
    for (int i = 0; i < 3; i++) begin
      check("seq_req_addr", accepted(i), 32'(4 * i));
      check("seq_inst_pc", popped(i), 32'(4 * i));
    end

    // Stalled decoder: credit caps requests at DEPTH.
    do_reset();
    imem_req_ready = 1'b1; lat = 1;
    repeat (10) tick();
    @(negedge clk);
    check("stall_accepts", acc_q.size(), 32'd4);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("stall_inst_pc", inst_pc, 32'h0);
    check("stall_inst_valid", {31'b0, inst_valid}, 32'h1);
    tick();
    inst_ready = 1'b1; pop_q.delete();
    wait_pops(5, 30);
    for (int i = 0; i < 5; i++) check("drain_pc", popped(i), 32'(4 * i));
    check("resume_addr", accepted(4), 32'h10);

    // Flush with two requests in flight at latency 3.
    do_reset();
    lat = 3; inst_ready = 1'b1;
    tick();
    imem_req_ready = 1'b1;
    tick(); tick();
    imem_req_ready = 1'b0; flush_pipe = 1'b1; redirect_pc = 32'h103;
    tick();
    flush_pipe = 1'b0; imem_req_ready = 1'b1; pop_q.delete();
    @(negedge clk);
    check("flush_bubble_req", {31'b0, imem_req_valid}, 32'h0);
    check("flush_drop_cnt", {29'b0, dut.drop_cnt}, 32'd2);
    tick();
    @(negedge clk);
    check("redirect_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("redirect_req_addr", imem_req_addr, 32'h100);
    wait_pops(2, 40);
    check("redirect_pc0", popped(0), 32'h100);
    check("redirect_pc1", popped(1), 32'h104);

    // Flush coinciding with the only outstanding response.
    do_reset();
    lat = 1; inst_ready = 1'b1;
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush_pipe = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("coinc_outstanding", {29'b0, dut.outstanding}, 32'd1);
    tick();
    flush_pipe = 1'b0; imem_req_ready = 1'b1; pop_q.delete();
    @(negedge clk);
    check("coinc_drop_cnt", {29'b0, dut.drop_cnt}, 32'd0);
    check("coinc_inst_valid", {31'b0, inst_valid}, 32'h0);
    wait_pops(1, 20);
    check("coinc_first_pc", popped(0), 32'h40);

    // Back-to-back flushes: only the second target survives.
    do_reset();
    lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (6) tick();
    flush_pipe = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    flush_pipe = 1'b0; pop_q.delete();
    wait_pops(3, 40);
    for (int i = 0; i < 3; i++) check("b2b_pc", popped(i), 32'h300 + 32'(4 * i));

    // Reset with a full buffer abandons everything.
    do_reset();
    lat = 1; imem_req_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("full_before_rst", {31'b0, dut.u_fifo.full}, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("midrst_outstanding", {29'b0, dut.outstanding}, 32'd0);
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("restart_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("restart_req_addr", imem_req_addr, 32'h0);

    // Randomized traffic, flushes, wrap-around targets and occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 599) != 0);
      flush_pipe     = rst && ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      tick();
    end
    rst = 1'b1; flush_pipe = 1'b0; inst_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
